e_mdu: RTL
==========

# e_mdu

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. Consumes the operands and decoded operation that the decode/execute pipeline register presents in E. Executes `mult`, `multu`, `div`, `divu`, `mfhi`, `mflo`, `mthi` and `mtlo` against architectural HI/LO registers. Exports a `busy` flag that the hazard unit uses to stall later multiply/divide instructions in D.

## Interface
- `MULT_CYCLES`, default 5: busy duration of `mult`/`multu`, in cycles.
- `DIV_CYCLES`, default 10: busy duration of `div`/`divu`, in cycles.

- `clk`  input  1: rising-edge clock.
- `reset`  input  1: asynchronous, active-low reset. Asserted when 0; clears all state immediately.
- `md_op`  input  4: operation code of the instruction currently in E; from the shared package.
- `rs_data`  input  32: forwarded rs operand.
- `rt_data`  input  32: forwarded rt operand.
- `busy`  output  1: registered; high while a mult/div is in flight.
- `md_result`  output  32: HI for `MD_MFHI`, LO for `MD_MFLO`, otherwise 0. Combinational from registered HI/LO.
- `hi`  output  32: architectural HI.
- `lo`  output  32: architectural LO.

## Operation
**Op codes (package)**
- `MD_NONE`=0, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MFHI`, `MD_MFLO`, `MD_MTHI`, `MD_MTLO`.
- Any other code behaves as `MD_NONE`.

**Acceptance**
- An op is accepted at a rising edge when `busy`=0.
- A mult/div/mthi/mtlo op presented while `busy`=1 is ignored; the hazard unit guarantees it never occurs. The bench asserts this.

**Multiply**
- `mult`: 64-bit signed product. `multu`: 64-bit unsigned product.
- Computed at acceptance and latched into pending {ph, pl}.
- Counter loaded with `MULT_CYCLES`.

**Divide**
- `div` is signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- `divu` is unsigned.
- LO = quotient, HI = remainder. Latched at acceptance.
- Counter loaded with `DIV_CYCLES`.
- Divisor 0: pending equals current HI/LO (registers unchanged), but the full busy period is still taken.
- Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.

**Moves**
- `mthi`/`mtlo`: HI/LO ← `rs_data` at the accepting edge. No busy.
- `mfhi`/`mflo`: pure reads. They never set busy, and the hazard unit stalls them while `busy`=1.

**States**
- IDLE (counter = 0) → RUN on accepting mult/div.
- RUN decrements the counter each edge.
- When the counter reaches 0, HI/LO ← pending and the unit returns to IDLE.
- `busy` = (counter ≠ 0).

## Timing
- **Reset:** `busy`=0, `hi`=0, `lo`=0, counter=0, pending=0, `md_result`=0. Reset mid-RUN discards the pending result; HI/LO are 0 after release.
- **Mult/div latency:** accepted at edge T0. `busy` is high from just after T0 through the cycle ending at edge T0+N (N = `MULT_CYCLES` or `DIV_CYCLES`). HI/LO take the result at edge T0+N, and `busy` falls at the same edge.
- **Back-to-back:** a new mult/div may be accepted at edge T0+N+1, i.e. the first edge with `busy`=0 sampled.
- **Hazard-unit stall condition:** stall a D-stage MD instruction when (`md_op` in E is mult/div) OR `busy`. This covers the accept cycle, before `busy` rises.
- **mthi/mtlo:** visible on `hi`/`lo` one edge after acceptance.
- **mfhi/mflo:** `md_result` valid in the same cycle as `md_op`.

## Structure
- **Shared package:** `MD_*` op codes, op width 4, default cycle counts.
- **Counter width:** $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- **Arithmetic:** combinational `*`, `/`, `%` on the appropriately signed 32-bit operands, with the special cases muxed ahead.
- **Sub-module:** one is natural, `mdu_arith`: combinational op, rs, rt → {hi_next, lo_next}, containing both special cases. The sequencing and registers stay in `e_mdu`.

## Test plan
- **Signed multiply:** reset release, then `mult` with rs=0xFFFFFFFE (-2), rt=3. Expect `busy`=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **Unsigned vs signed divide:** `divu` 7/2 → after 10 busy cycles HI=1, LO=3. `div` -7/2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- **Divide special cases:** `mthi` 0x11, `mtlo` 0x22, then `div` x/0. Expect 10 busy cycles, then HI=0x11, LO=0x22. `div` 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Moves and reads:** `mtlo` 0xDEADBEEF then `mflo` the next cycle → `md_result`=0xDEADBEEF. `mfhi` while idle → current HI.
- **Reset mid-operation:** `multu` 0xFFFFFFFF×0xFFFFFFFF, then drive `reset`=0 at busy cycle 3. Expect `busy`, HI and LO go to 0 immediately with no later update. A `multu` 2×3 after release gives LO=6 five cycles later.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Holds the MD op codes, the op width and the default busy durations.
package e_mdu_pkg;

  localparam int unsigned MdOpW             = 4;
  localparam int unsigned MultCyclesDefault = 5;
  localparam int unsigned DivCyclesDefault  = 10;

  typedef enum logic [MdOpW-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  // True for the ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_mul_div(input logic [MdOpW-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   op_i        - MD op code
//   rs_i, rt_i  - operands
//   hi_i, lo_i  - current architectural HI/LO (returned for divide-by-zero and non-arith ops)
//   hi_o, lo_o  - result destined for HI/LO once the busy period ends
module e_mdu_arith
  import e_mdu_pkg::*;
(
  input  logic [MdOpW-1:0] op_i,
  input  logic [31:0]      rs_i,
  input  logic [31:0]      rt_i,
  input  logic [31:0]      hi_i,
  input  logic [31:0]      lo_i,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o
);

  logic [63:0]        rs_sx, rt_sx, prod_s, prod_u;
  logic signed [31:0] rs_s, rt_s, quot_s, rem_s;
  logic               div_zero, div_ovf;

  assign rs_sx  = {{32{rs_i[31]}}, rs_i};
  assign rt_sx  = {{32{rt_i[31]}}, rt_i};
  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

  assign rs_s   = $signed(rs_i);
  assign rt_s   = $signed(rt_i);
  assign quot_s = rs_s / rt_s;
  assign rem_s  = rs_s % rt_s;

  assign div_zero = (rt_i == 32'd0);
  // Most-negative / -1 overflows; the architectural answer is pinned explicitly.
  assign div_ovf  = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);

  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    case (op_i)
      MD_MULT:  {hi_o, lo_o} = prod_s;
      MD_MULTU: {hi_o, lo_o} = prod_u;
      MD_DIV: begin
        if (div_ovf) begin
          hi_o = 32'd0;
          lo_o = 32'h8000_0000;
        end else if (!div_zero) begin
          hi_o = rem_s;
          lo_o = quot_s;
        end
      end
      MD_DIVU: begin
        if (!div_zero) begin
          hi_o = rs_i % rt_i;
          lo_o = rs_i / rt_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit with architectural HI/LO.
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-low reset
//   md_op             - op code of the instruction in E
//   rs_data, rt_data  - forwarded operands
//   busy              - high while a mult/div is in flight (registered)
//   md_result         - HI for mfhi, LO for mflo, else 0
//   hi, lo            - architectural HI/LO
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDefault,
  parameter int unsigned DIV_CYCLES  = DivCyclesDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MdOpW-1:0] md_op,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic             busy,
  output logic [31:0]      md_result,
  output logic [31:0]      hi,
  output logic [31:0]      lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     ph_q, ph_d, pl_q, pl_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            busy_q;
  logic [31:0]     arith_hi, arith_lo;

  e_mdu_arith u_arith (
    .op_i (md_op),
    .rs_i (rs_data),
    .rt_i (rt_data),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .hi_o (arith_hi),
    .lo_o (arith_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        case (md_op)
          MD_MULT, MD_MULTU: begin
            cnt_d   = CntW'(MULT_CYCLES);
            ph_d    = arith_hi;
            pl_d    = arith_lo;
            state_d = StRun;
          end
          MD_DIV, MD_DIVU: begin
            cnt_d   = CntW'(DIV_CYCLES);
            ph_d    = arith_hi;
            pl_d    = arith_lo;
            state_d = StRun;
          end
          MD_MTHI: hi_d = rs_data;
          MD_MTLO: lo_d = rs_data;
          default: ;
        endcase
      end
      StRun: begin
        // Ops arriving here are dropped; the hazard unit keeps them in D.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          hi_d    = ph_q;
          lo_d    = pl_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (cnt_d != '0);
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    md_result = 32'd0;
    if (md_op == MD_MFHI) begin
      md_result = hi_q;
    end else if (md_op == MD_MFLO) begin
      md_result = lo_q;
    end
  end

endmodule
